// File: rtl/four_llader.sv
// 4-bit ripple-borrow subtractor, A - B - borrow-in, with registered outputs.
// Ports: clk, rst (sync, active-high), in_a*/in_b* operand bits, in_pa0
// borrow-in; out_s* registered difference bits, out_pa registered borrow-out.
module four_llader (
  input  logic clk,
  input  logic rst,
  input  logic in_a0,
  input  logic in_a1,
  input  logic in_a2,
  input  logic in_a3,
  input  logic in_b0,
  input  logic in_b1,
  input  logic in_b2,
  input  logic in_b3,
  input  logic in_pa0,
  output logic out_s0,
  output logic out_s1,
  output logic out_s2,
  output logic out_s3,
  output logic out_pa
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] d;
  logic [4:0] bw;

  logic [3:0] s_d;
  logic [3:0] s_q;
  logic       pa_d;
  logic       pa_q;

  assign a = {in_a3, in_a2, in_a1, in_a0};
  assign b = {in_b3, in_b2, in_b1, in_b0};

  // Chain of four full-subtractor cells; bw[i] is the borrow into cell i.
  always_comb begin
    d     = '0;
    bw    = '0;
    bw[0] = in_pa0;
    for (int i = 0; i < 4; i++) begin
      d[i]    = a[i] ^ b[i] ^ bw[i];
      bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
  end

  always_comb begin
    s_d  = d;
    pa_d = bw[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      pa_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      pa_q <= pa_d;
    end
  end

  assign out_s0 = s_q[0];
  assign out_s1 = s_q[1];
  assign out_s2 = s_q[2];
  assign out_s3 = s_q[3];
  assign out_pa = pa_q;

endmodule

// File: tb/tb_four_llader.sv
// Scoreboard bench for four_llader: driver pushes expected results,
// monitor pops one per clock edge and compares.
module tb_four_llader;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] a;
  logic [3:0] b;
  logic bin;
  logic out_s0, out_s1, out_s2, out_s3, out_pa;

  typedef struct {
    logic [3:0] s;
    logic       pa;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  always #5 clk = ~clk;

  four_llader dut (
    .clk(clk), .rst(rst),
    .in_a0(a[0]), .in_a1(a[1]), .in_a2(a[2]), .in_a3(a[3]),
    .in_b0(b[0]), .in_b1(b[1]), .in_b2(b[2]), .in_b3(b[3]),
    .in_pa0(bin),
    .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
    .out_pa(out_pa)
  );

  // Drive one cycle of stimulus and record what the next edge must produce.
  task automatic step(input logic r, input int av, input int bv,
                      input int bi, input int tag);
    exp_t e;
    int diff;
    @(negedge clk);
    rst = r;
    a   = av[3:0];
    b   = bv[3:0];
    bin = bi[0];
    diff = av - bv - bi;
    if (r) begin
      e.s  = 4'd0;
      e.pa = 1'b0;
    end else begin
      e.s  = 4'(((diff % 16) + 16) % 16);
      e.pa = (diff < 0);
    end
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one registered result per edge while expectations are pending.
  initial begin
    exp_t e;
    logic [3:0] s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = {out_s3, out_s2, out_s1, out_s0};
        checks++;
        if (s !== e.s) begin
          errors++;
          $display("FAIL diff tag=%0d actual=%b required=%b", e.tag, s, e.s);
        end
        checks++;
        if (out_pa !== e.pa) begin
          errors++;
          $display("FAIL borrow tag=%0d actual=%b required=%b",
                   e.tag, out_pa, e.pa);
        end
      end
    end
  end

  initial begin
    int tag;
    int rst_at;
    rst = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    tag = 0;

    // Reset held for two edges, then release.
    step(1, 15, 0, 0, tag++);
    step(1, 15, 0, 0, tag++);
    step(0, 15, 0, 0, tag++);

    // Directed cases.
    step(0, 9, 4, 0, tag++);
    step(0, 8, 7, 1, tag++);
    step(0, 3, 5, 0, tag++);
    step(0, 0, 0, 1, tag++);
    step(0, 0, 1, 0, tag++);
    step(0, 15, 15, 1, tag++);

    // Exhaustive sweep with a one-cycle reset inserted partway through.
    rst_at = 300;
    for (int i = 0; i < 512; i++) begin
      if (i == rst_at) step(1, i[8:5], i[4:1], i[0], tag++);
      step(0, i[8:5], i[4:1], i[0], tag++);
    end

    // Random back-to-back traffic with sporadic resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1), tag++);
    end

    // Drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
